// File: rtl/uart_rx.sv
// 8N1 serial receiver with oversampled majority voting,
// framing/break detection and a single-entry holding register.
module uart_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [CW-1:0] TOP    = CW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(M - 1);
  localparam logic [SW-1:0] S_B    = SW'(M);
  localparam logic [SW-1:0] S_C    = SW'(M + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t          state;
  logic            sync1;
  logic            rxs;
  logic            rxs_d;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   s;
  logic            va;
  logic            vb;
  logic [2:0]      bitn;
  logic [7:0]      sh;
  logic            done;
  logic            tick;
  logic            decide;
  logic            maj;

  assign tick   = (state != IDLE) && (cnt == TOP);
  assign decide = tick && (s == S_C);
  assign maj    = (va & vb) | (va & rxs) | (vb & rxs);
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1       <= 1'b1;
      rxs         <= 1'b1;
      rxs_d       <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      s           <= '0;
      va          <= 1'b0;
      vb          <= 1'b0;
      bitn        <= '0;
      sh          <= '0;
      done        <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync1       <= rx;
      rxs         <= sync1;
      rxs_d       <= rxs;
      done        <= 1'b0;
      framing_err <= 1'b0;
      // phase counter restarts from zero on every start edge
      if (state == IDLE || tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (tick) begin
        s <= (s == S_LAST) ? '0 : s + 1'b1;
        if (s == S_A) va <= rxs;
        if (s == S_B) vb <= rxs;
      end
      unique case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (decide) begin
            state <= maj ? IDLE : DATA;
            bitn  <= '0;
          end
        end
        DATA: begin
          if (decide) begin
            sh <= {maj, sh[7:1]};
            if (bitn == 3'd7)
              state <= STOP;
            else
              bitn <= bitn + 1'b1;
          end
        end
        STOP: begin
          if (decide) begin
            if (maj) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state       <= BRK;
              framing_err <= 1'b1;
            end
          end
        end
        BRK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data  <= sh;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frame stream plus
// hand-written glitch, break, overrun and reset sequences.
module tb_uart_rx;

  localparam int BIT = 160;

  logic       CLK;
  logic       RST;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic       stop_bit;
  } vec_t;

  vec_t vecs[4];

  uart_rx #(
    .CLK_HZ(1600000),
    .BAUD(10000),
    .OVERSAMPLE(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .framing_err(framing_err),
    .overrun(overrun),
    .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT);
    end
    rx = stop_bit;
    wait_clk(BIT);
    rx = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int maxc);
    int k;
    k = 0;
    @(negedge CLK);
    while (busy !== lvl && k < maxc) begin
      @(negedge CLK);
      k++;
    end
    if (busy !== lvl) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_busy: timeout, got %b, expected %b", busy, lvl);
    end
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    wait_clk(1);
    ready = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [7:0] e;
    #2;
    if (!RST) begin
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL accept: got unexpected byte %h, expected none", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL accept: got %h, expected %h", data, e);
          end
        end
      end
    end
  end

  initial begin
    int fe0;
    int ov0;
    vecs[0] = '{8'h00, 1'b1};
    vecs[1] = '{8'hFF, 1'b1};
    vecs[2] = '{8'h55, 1'b1};
    vecs[3] = '{8'h80, 1'b1};

    RST   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    wait_clk(5);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_fe", 32'(framing_err), 32'h0);
    check("rst_ov", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    RST = 1'b0;
    wait_clk(BIT);

    // single byte, consumer not ready
    send(8'hA5, 1'b1);
    @(negedge CLK);
    check("single_valid", 32'(valid), 32'h1);
    check("single_data", 32'(data), 32'hA5);
    check("single_fe", 32'(fe_cnt), 32'h0);
    check("single_ov", 32'(ov_cnt), 32'h0);
    exp_q.push_back(8'hA5);
    wait_clk(1);
    pulse_ready();
    @(negedge CLK);
    check("single_drop", 32'(valid), 32'h0);
    check("single_hold", 32'(data), 32'hA5);
    wait_clk(BIT);

    // back-to-back stream, ready held high
    ready = 1'b1;
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].stop_bit) exp_q.push_back(vecs[i].b);
      send(vecs[i].b, vecs[i].stop_bit);
      check("stream_fe", 32'(fe_cnt), 32'(fe0));
    end
    wait_clk(BIT);
    check("stream_left", 32'(exp_q.size()), 32'h0);
    check("stream_ov", 32'(ov_cnt), 32'h0);

    // glitch
    fe0 = fe_cnt;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(3);
    check("glitch_busy", 32'(busy), 32'h1);
    wait_clk(BIT);
    check("glitch_idle", 32'(busy), 32'h0);
    check("glitch_valid", 32'(valid), 32'h0);
    check("glitch_fe", 32'(fe_cnt), 32'(fe0));

    // bad stop bit, then break
    ready = 1'b0;
    send(8'h3C, 1'b0);
    wait_clk(2 * BIT);
    check("frame_fe", 32'(fe_cnt), 32'(fe0 + 1));
    check("frame_valid", 32'(valid), 32'h0);
    rx = 1'b0;
    wait_clk(20 * BIT);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check("break_fe", 32'(fe_cnt), 32'(fe0 + 2));
    ready = 1'b1;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    wait_clk(BIT);
    check("break_rx", 32'(exp_q.size()), 32'h0);
    check("break_fe2", 32'(fe_cnt), 32'(fe0 + 2));

    // overrun
    ready = 1'b0;
    ov0 = ov_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wait_clk(BIT);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_pulse", 32'(ov_cnt), 32'(ov0 + 1));
    exp_q.push_back(8'h11);
    pulse_ready();
    @(negedge CLK);
    check("ovr_drain", 32'(valid), 32'h0);
    wait_clk(BIT);

    // accept on the completion cycle of the second byte
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
      end
      begin
        wait_busy(1'b1, 2 * BIT);
        wait_busy(1'b0, 11 * BIT);
        wait_busy(1'b1, 2 * BIT);
        wait_busy(1'b0, 11 * BIT);
        #1;
        ready = 1'b1;
        @(posedge CLK);
        #1;
        ready = 1'b0;
      end
    join
    wait_clk(BIT);
    check("same_data", 32'(data), 32'h22);
    check("same_valid", 32'(valid), 32'h1);
    check("same_ov", 32'(ov_cnt), 32'(ov0));
    pulse_ready();
    wait_clk(BIT);
    check("same_left", 32'(exp_q.size()), 32'h0);

    // reset in the middle of bit 4 of 0x96
    send(8'h5A, 1'b1);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ^ i[1];
      wait_clk(BIT);
    end
    rx = 1'b1;
    wait_clk(BIT / 2);
    check("pre_rst_valid", 32'(valid), 32'h1);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("arst_data", 32'(data), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_fe", 32'(framing_err), 32'h0);
    check("arst_ov", 32'(overrun), 32'h0);
    wait_clk(4);
    RST = 1'b0;
    wait_clk(2 * BIT);
    ready = 1'b1;
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1);
    wait_clk(BIT);
    check("post_rst_left", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
